// File: rtl/serv_rf_ram_clr_if.sv
// RAM-side bus between serv_rf_ram_if and the clearing register-file RAM.
// Write/read strobes are plain qualifiers: a request takes effect at the clock edge where it is high.
interface serv_rf_ram_clr_if #(
    parameter int width = 8,
    parameter int aw    = 8
);
    logic [aw-1:0]    i_waddr;
    logic [width-1:0] i_wdata;
    logic             i_wen;
    logic [aw-1:0]    i_raddr;
    logic             i_ren;
    logic [width-1:0] o_rdata;
    logic             o_busy;
    logic             o_perr;

    modport master (
        output i_waddr, i_wdata, i_wen, i_raddr, i_ren,
        input  o_rdata, o_busy, o_perr
    );

    modport slave (
        input  i_waddr, i_wdata, i_wen, i_raddr, i_ren,
        output o_rdata, o_busy, o_perr
    );
endinterface

// File: rtl/serv_rf_ram_clr.sv
// Register-file RAM that zeroes every word after reset before accepting traffic.
// Optional per-word even parity is enabled with `define SERV_RF_RAM_PARITY_EN.
module serv_rf_ram_clr #(
    parameter int width    = 8,
    parameter int csr_regs = 4,
    parameter int aw       = 5 + $clog2(32 + csr_regs) - $clog2(width)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    serv_rf_ram_clr_if.slave   bus,
    output logic [1:0]         o_dbg_state
);
    localparam int depth = 2 ** aw;
`ifdef SERV_RF_RAM_PARITY_EN
    localparam int mw = width + 1;
`else
    localparam int mw = width;
`endif

    typedef enum logic [1:0] {ST_RST = 2'd0, ST_CLEAR = 2'd1, ST_RUN = 2'd2} state_e;

    logic [mw-1:0]    mem_q [depth];
    state_e           state_q, state_d;
    logic [aw-1:0]    clr_cnt_q, clr_cnt_d;
    logic [width-1:0] rdata_q, rdata_d;
    logic             perr_q, perr_d;
    logic             busy_q, busy_d;
    logic             mem_we;
    logic [aw-1:0]    mem_waddr;
    logic [mw-1:0]    mem_wword;
    logic [mw-1:0]    rd_word;

    // Stored word: data plus, when enabled, a bit that makes the total popcount even.
    function automatic logic [mw-1:0] encode(input logic [width-1:0] d);
`ifdef SERV_RF_RAM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rdata_d   = rdata_q;
        perr_d    = perr_q;
        mem_we    = 1'b0;
        mem_waddr = bus.i_waddr;
        mem_wword = encode(bus.i_wdata);
        rd_word   = mem_q[bus.i_raddr];
        case (state_q)
            ST_RST: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
                rdata_d   = '0;
                perr_d    = 1'b0;
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wword = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                rdata_d   = '0;
                perr_d    = 1'b0;
                if (clr_cnt_q == {aw{1'b1}}) state_d = ST_RUN;
            end
            ST_RUN: begin
                mem_we = bus.i_wen;
                // Read samples the array before this edge's write lands: old data on collision.
                if (bus.i_ren) begin
                    rdata_d = rd_word[width-1:0];
`ifdef SERV_RF_RAM_PARITY_EN
                    perr_d  = ^rd_word;
`else
                    perr_d  = 1'b0;
`endif
                end
            end
            default: state_d = ST_RST;
        endcase
        if (i_rst) mem_we = 1'b0;
        busy_d = (state_d != ST_RUN);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_RST;
            clr_cnt_q <= '0;
            rdata_q   <= '0;
            perr_q    <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rdata_q   <= rdata_d;
            perr_q    <= perr_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wword;
    end

    assign bus.o_rdata = rdata_q;
    assign bus.o_perr  = perr_q;
    assign bus.o_busy  = busy_q;
    assign o_dbg_state = state_q;
endmodule
